// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: alignment checks, req/ack data bus, upstream stall and MEM/WB slot.
// Load data leaves right-justified but unextended; WB applies sign/zero extension from wb_funct3.
module mem_access_unit #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    input  logic [31:0] ex_alu_result,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_mem_read,
    output logic        wb_reg_write,
    output logic [2:0]  wb_funct3,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_load_data,
    output logic        addr_exc,
    output logic        bus_err,
    output logic [31:0] err_addr,
    output logic        dbg_state
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt;
    logic          access, illegal_op, misaligned, fault, good;
    logic          ack_done, timeout;
    logic [3:0]    wstrb_c;
    logic [31:0]   wdata_c, load_c;

    assign dbg_state = (state == BUSY);

    always_comb begin
        access     = ex_valid & (ex_mem_read | ex_mem_write);
        illegal_op = 1'b0;
        if (ex_mem_read & ex_mem_write)
            illegal_op = 1'b1;
        else if (ex_mem_read)
            illegal_op = !(ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else
            illegal_op = !(ex_funct3 inside {3'b000, 3'b001, 3'b010});
        misaligned = ((ex_funct3[1:0] == 2'b01) & ex_addr[0])
                   | ((ex_funct3[1:0] == 2'b10) & (ex_addr[1:0] != 2'b00));
        fault      = access & (illegal_op | misaligned);
        good       = access & !fault;
    end

    always_comb begin
        wstrb_c = 4'b1111;
        wdata_c = ex_store_data;
        case (ex_funct3[1:0])
            2'b00: begin
                wstrb_c = 4'b0001 << ex_addr[1:0];
                wdata_c = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                wstrb_c = 4'b0011 << ex_addr[1:0];
                wdata_c = {2{ex_store_data[15:0]}};
            end
            default: ;
        endcase
        // EX/MEM is frozen while BUSY, so ex_addr still describes the access in flight.
        load_c = ex_mem_read ? (dmem_rdata >> {ex_addr[1:0], 3'b000}) : 32'h0;
    end

    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        ack_done   = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (good) begin
                    state_next = BUSY;
                    mem_stall  = 1'b1;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    ack_done   = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == LAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end else begin
                    mem_stall  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst)
            mem_stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt      <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 32'h0;
            dmem_wdata    <= 32'h0;
            dmem_wstrb    <= 4'h0;
            wb_valid      <= 1'b0;
            wb_mem_read   <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_funct3     <= 3'h0;
            wb_rd         <= 5'h0;
            wb_alu_result <= 32'h0;
            wb_load_data  <= 32'h0;
            addr_exc      <= 1'b0;
            bus_err       <= 1'b0;
            err_addr      <= 32'h0;
        end else begin
            addr_exc <= 1'b0;
            bus_err  <= 1'b0;
            if (state == IDLE) begin
                if (good) begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= ex_mem_write;
                    dmem_addr  <= {ex_addr[31:2], 2'b00};
                    dmem_wdata <= wdata_c;
                    dmem_wstrb <= ex_mem_write ? wstrb_c : 4'h0;
                    wait_cnt   <= '0;
                    wb_valid   <= 1'b0;
                end else begin
                    wb_valid      <= ex_valid & !fault;
                    wb_mem_read   <= ex_mem_read & !fault;
                    wb_reg_write  <= ex_reg_write & !fault;
                    wb_funct3     <= ex_funct3;
                    wb_rd         <= ex_rd;
                    wb_alu_result <= ex_alu_result;
                    wb_load_data  <= 32'h0;
                    if (fault) begin
                        addr_exc <= 1'b1;
                        err_addr <= ex_addr;
                    end
                end
            end else if (ack_done || timeout) begin
                dmem_req      <= 1'b0;
                dmem_we       <= 1'b0;
                dmem_addr     <= 32'h0;
                dmem_wdata    <= 32'h0;
                dmem_wstrb    <= 4'h0;
                wait_cnt      <= '0;
                wb_valid      <= ack_done;
                wb_mem_read   <= ack_done & ex_mem_read;
                wb_reg_write  <= ack_done & ex_reg_write;
                wb_funct3     <= ex_funct3;
                wb_rd         <= ex_rd;
                wb_alu_result <= ex_alu_result;
                wb_load_data  <= ack_done ? load_c : 32'h0;
                if (timeout) begin
                    bus_err  <= 1'b1;
                    err_addr <= ex_addr;
                end
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
                wb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of single accesses plus hand-written
// sequences for wait states, timeout, ack on the last count and reset during an access.
module tb_mem_access_unit;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_store_data, ex_alu_result;
    logic [4:0]  ex_rd;
    logic        mem_stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        wb_valid, wb_mem_read, wb_reg_write;
    logic [2:0]  wb_funct3;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu_result, wb_load_data, err_addr;
    logic        addr_exc, bus_err, dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
        .ex_alu_result(ex_alu_result), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_mem_read(wb_mem_read), .wb_reg_write(wb_reg_write),
        .wb_funct3(wb_funct3), .wb_rd(wb_rd), .wb_alu_result(wb_alu_result),
        .wb_load_data(wb_load_data), .addr_exc(addr_exc), .bus_err(bus_err),
        .err_addr(err_addr), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, sdata, rdata, alu;
        logic        exc, req;
        logic [3:0]  wstrb;
        logic [31:0] wdata, load;
        logic        wbv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic valid, logic rd, logic wr, logic [2:0] f3,
                                logic [31:0] addr, logic [31:0] sdata, logic [31:0] rdata,
                                logic [31:0] alu, logic exc, logic req, logic [3:0] wstrb,
                                logic [31:0] wdata, logic [31:0] load, logic wbv);
        vec_t v;
        v.valid = valid; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr;
        v.sdata = sdata; v.rdata = rdata; v.alu = alu; v.exc = exc; v.req = req;
        v.wstrb = wstrb; v.wdata = wdata; v.load = load; v.wbv = wbv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] alu, input logic [4:0] rdn);
        ex_valid = valid; ex_mem_read = rd; ex_mem_write = wr; ex_funct3 = f3;
        ex_addr = addr; ex_store_data = sdata; ex_alu_result = alu; ex_rd = rdn;
        ex_reg_write = rd | !wr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        drive(v.valid, v.rd, v.wr, v.f3, v.addr, v.sdata, v.alu, 5'(idx));
        #1;
        chk($sformatf("v%0d_stall", idx), 32'(mem_stall), 32'(v.req));
        tick();
        chk($sformatf("v%0d_req", idx), 32'(dmem_req), 32'(v.req));
        chk($sformatf("v%0d_addr_exc", idx), 32'(addr_exc), 32'(v.exc));
        if (v.exc)
            chk($sformatf("v%0d_err_addr", idx), err_addr, v.addr);
        if (v.req) begin
            chk($sformatf("v%0d_we", idx), 32'(dmem_we), 32'(v.wr));
            chk($sformatf("v%0d_daddr", idx), dmem_addr, {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d_wstrb", idx), 32'(dmem_wstrb), 32'(v.wstrb));
            if (v.wr)
                chk($sformatf("v%0d_wdata", idx), dmem_wdata, v.wdata);
            dmem_ack = 1'b1;
            dmem_rdata = v.rdata;
            #1;
            chk($sformatf("v%0d_ack_stall", idx), 32'(mem_stall), 32'h0);
            tick();
            dmem_ack = 1'b0;
            chk($sformatf("v%0d_req_drop", idx), 32'(dmem_req), 32'h0);
        end
        chk($sformatf("v%0d_wb_valid", idx), 32'(wb_valid), 32'(v.wbv));
        if (v.wbv) begin
            chk($sformatf("v%0d_wb_alu", idx), wb_alu_result, v.alu);
            chk($sformatf("v%0d_wb_rd", idx), 32'(wb_rd), idx);
            chk($sformatf("v%0d_wb_f3", idx), 32'(wb_funct3), 32'(v.f3));
            chk($sformatf("v%0d_wb_mrd", idx), 32'(wb_mem_read), 32'(v.rd));
            chk($sformatf("v%0d_wb_load", idx), wb_load_data, v.load);
        end
    endtask

    initial begin
        int stalls, req_cycles;
        logic last_stall;

        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 5'd1);

        // Reset: all outputs zero, stall suppressed even with a legal load presented.
        #1;
        chk("rst_stall", 32'(mem_stall), 32'h0);
        tick();
        tick();
        chk("rst_stall2", 32'(mem_stall), 32'h0);
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_wstrb", 32'(dmem_wstrb), 32'h0);
        chk("rst_wb_valid", 32'(wb_valid), 32'h0);
        chk("rst_load", wb_load_data, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_pulses", {30'h0, addr_exc, bus_err}, 32'h0);
        chk("rst_state", 32'(dbg_state), 32'h0);
        ex_valid = 1'b0;
        rst = 1'b0;
        tick();

        //        valid rd wr f3      addr          sdata         rdata         alu           exc req wstrb   wdata         load          wbv
        vecs.push_back(mk(1, 0, 0, 3'b000, 32'h0,      32'h0,        32'h0,        32'h12345678, 0, 0, 4'h0, 32'h0,        32'h0,        1));
        vecs.push_back(mk(0, 1, 0, 3'b010, 32'h100,    32'h0,        32'h0,        32'hAAAA0000, 0, 0, 4'h0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 0, 3'b010, 32'h100,    32'h0,        32'hDEADBEEF, 32'h100,      0, 1, 4'h0, 32'h0,        32'hDEADBEEF, 1));
        vecs.push_back(mk(1, 1, 0, 3'b100, 32'h1003,   32'h0,        32'hAABBCCDD, 32'h1003,     0, 1, 4'h0, 32'h0,        32'h000000AA, 1));
        vecs.push_back(mk(1, 1, 0, 3'b001, 32'h2002,   32'h0,        32'h11223344, 32'h2002,     0, 1, 4'h0, 32'h0,        32'h00001122, 1));
        vecs.push_back(mk(1, 1, 0, 3'b000, 32'h0001,   32'h0,        32'h11223344, 32'h1,        0, 1, 4'h0, 32'h0,        32'h00112233, 1));
        vecs.push_back(mk(1, 1, 0, 3'b101, 32'h2000,   32'h0,        32'h8000FFFF, 32'h2000,     0, 1, 4'h0, 32'h0,        32'h8000FFFF, 1));
        vecs.push_back(mk(1, 0, 1, 3'b001, 32'h2002,   32'h00001234, 32'hFFFFFFFF, 32'h2002,     0, 1, 4'hC, 32'h12341234, 32'h0,        1));
        vecs.push_back(mk(1, 0, 1, 3'b000, 32'h3001,   32'h000000A5, 32'hFFFFFFFF, 32'h3001,     0, 1, 4'h2, 32'hA5A5A5A5, 32'h0,        1));
        vecs.push_back(mk(1, 0, 1, 3'b000, 32'h3003,   32'h12345678, 32'hFFFFFFFF, 32'h3003,     0, 1, 4'h8, 32'h78787878, 32'h0,        1));
        vecs.push_back(mk(1, 0, 1, 3'b010, 32'h4000,   32'hCAFEF00D, 32'hFFFFFFFF, 32'h4000,     0, 1, 4'hF, 32'hCAFEF00D, 32'h0,        1));
        vecs.push_back(mk(1, 1, 0, 3'b010, 32'h1001,   32'h0,        32'h0,        32'h0,        1, 0, 4'h0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 0, 3'b001, 32'h1003,   32'h0,        32'h0,        32'h0,        1, 0, 4'h0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 0, 1, 3'b010, 32'h2002,   32'h0,        32'h0,        32'h0,        1, 0, 4'h0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 0, 1, 3'b001, 32'h2001,   32'h0,        32'h0,        32'h0,        1, 0, 4'h0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 1, 3'b010, 32'h500,    32'h0,        32'h0,        32'h0,        1, 0, 4'h0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 0, 3'b011, 32'h600,    32'h0,        32'h0,        32'h0,        1, 0, 4'h0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 0, 1, 3'b100, 32'h700,    32'h0,        32'h0,        32'h0,        1, 0, 4'h0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 1, 0, 3'b101, 32'h2001,   32'h0,        32'h0,        32'h0,        1, 0, 4'h0, 32'h0,        32'h0,        0));

        foreach (vecs[i]) run_vec(vecs[i], i);

        // addr_exc is a single-cycle pulse.
        ex_valid = 1'b0;
        tick();
        chk("exc_pulse_end", 32'(addr_exc), 32'h0);

        // LBU 0x1003 with three wait states: four stall cycles, wb_valid at T+5.
        drive(1'b1, 1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 32'h1003, 5'd9);
        stalls = 0;
        #1;
        if (mem_stall) stalls++;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ws_req%0d", i), 32'(dmem_req), 32'h1);
            chk($sformatf("ws_bubble%0d", i), 32'(wb_valid), 32'h0);
            if (mem_stall) stalls++;
            tick();
        end
        dmem_ack = 1'b1;
        dmem_rdata = 32'hAABBCCDD;
        #1;
        if (mem_stall) stalls++;
        tick();
        dmem_ack = 1'b0;
        ex_valid = 1'b0;
        chk("ws_stall_cycles", stalls, 32'd4);
        chk("ws_wb_valid", 32'(wb_valid), 32'h1);
        chk("ws_load", wb_load_data, 32'h000000AA);
        chk("ws_f3", 32'(wb_funct3), 32'h4);
        chk("ws_req_drop", 32'(dmem_req), 32'h0);

        // SW with no ack: request held MAX_WAIT cycles, then bus_err pulse.
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h5004, 32'h0BADF00D, 32'h5004, 5'd10);
        #1;
        chk("to_stall0", 32'(mem_stall), 32'h1);
        tick();
        chk("to_wdata", dmem_wdata, 32'h0BADF00D);
        req_cycles = 0;
        last_stall = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (!dmem_req) break;
            req_cycles++;
            last_stall = mem_stall;
            tick();
            if (!last_stall) ex_valid = 1'b0;
        end
        chk("to_req_cycles", req_cycles, MAX_WAIT);
        chk("to_last_stall", 32'(last_stall), 32'h0);
        chk("to_bus_err", 32'(bus_err), 32'h1);
        chk("to_wb_valid", 32'(wb_valid), 32'h0);
        chk("to_err_addr", err_addr, 32'h5004);
        chk("to_state", 32'(dbg_state), 32'h0);
        tick();
        chk("to_pulse_end", 32'(bus_err), 32'h0);
        chk("to_no_reissue", 32'(dmem_req), 32'h0);

        // Ack in the same cycle as the final count completes the access.
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h40, 5'd11);
        tick();
        for (int i = 0; i < MAX_WAIT - 1; i++) tick();
        chk("last_req", 32'(dmem_req), 32'h1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0F0F1234;
        #1;
        chk("last_stall", 32'(mem_stall), 32'h0);
        tick();
        dmem_ack = 1'b0;
        ex_valid = 1'b0;
        chk("last_wb_valid", 32'(wb_valid), 32'h1);
        chk("last_bus_err", 32'(bus_err), 32'h0);
        chk("last_load", wb_load_data, 32'h0F0F1234);

        // Reset while BUSY abandons the access; a late ack is ignored.
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 32'h80, 5'd12);
        tick();
        chk("rb_req", 32'(dmem_req), 32'h1);
        rst = 1'b1;
        #1;
        chk("rb_stall_forced", 32'(mem_stall), 32'h0);
        tick();
        rst = 1'b0;
        ex_valid = 1'b0;
        chk("rb_req_drop", 32'(dmem_req), 32'h0);
        chk("rb_state", 32'(dbg_state), 32'h0);
        chk("rb_wb_valid", 32'(wb_valid), 32'h0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h12345678;
        tick();
        dmem_ack = 1'b0;
        chk("rb_late_wb", 32'(wb_valid), 32'h0);
        chk("rb_late_load", wb_load_data, 32'h0);
        chk("rb_late_pulses", {30'h0, addr_exc, bus_err}, 32'h0);
        chk("rb_late_req", 32'(dmem_req), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
